match_pipe: RTL and testbench

MATCH_PIPE -- requirements
Module: match_pipe

---
 rtl/match_pipe.sv | 126 ++++++++++++
 tb/tb_match_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/match_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : match_pipe
//  Purpose  : Fixed-latency, stallable, flushable pipe carrying CHANNELS valid
//             bits plus one TAG_WIDTH sideband tag per stage. Valids and tags
//             travel together. The tag is meaningful only where the matching
//             o_valid has a set bit.
//  Ports    : clk       - single clock, rising edge
//             reset     - synchronous, active-high; clears valids and tags
//             en        - 1 advances the pipe, 0 holds it
//             flush     - clears every in-flight valid; tags hold
//             i_valid   - per-channel valid into stage 0
//             i_tag     - tag into stage 0
//             o_valid   - per-channel valid out of the last stage
//             o_tag     - tag out of the last stage
//             busy      - OR of all held valid bits (register-derived only)
//             inflight  - number of valid bits held across all stages
//  Priority : reset > flush > en
//  Options  : MATCH_PIPE_INFLIGHT_EN - when defined, builds the inflight
//             counter; otherwise inflight is tied to 0
//             DELAY == 0 gives a combinational pass-through with busy and
//             inflight at 0 and en/flush ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module match_pipe #(
    parameter int  CHANNELS  = 1,
    parameter int  TAG_WIDTH = 8,
    parameter int  DELAY     = 4,
    localparam int CNT_WIDTH = ($clog2(CHANNELS*DELAY+1) < 1) ? 1
                                : $clog2(CHANNELS*DELAY+1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic [CHANNELS-1:0]  i_valid,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic [CHANNELS-1:0]  o_valid,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] inflight
);

    function automatic int popcnt(input logic [CHANNELS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

    if (DELAY == 0) begin : g_bypass
        // No storage at all: the pipe degenerates to wires.
        assign o_valid  = i_valid;
        assign o_tag    = i_tag;
        assign busy     = 1'b0;
        assign inflight = '0;

        logic w_unused;
        assign w_unused = &{1'b0, clk, reset, en, flush};
    end else begin : g_pipe
        logic [CHANNELS-1:0]  r_valid [DELAY];
        logic [TAG_WIDTH-1:0] r_tag   [DELAY];
        logic                 w_busy;

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < DELAY; k++) begin
                    r_valid[k] <= '0;
                    r_tag[k]   <= '0;
                end
            end else if (flush) begin
                // Tags are left alone; with no valid beside them they are
                // don't-care anyway and this saves a clear path on the tags.
                for (int k = 0; k < DELAY; k++) begin
                    r_valid[k] <= '0;
                end
            end else if (en) begin
                r_valid[0] <= i_valid;
                r_tag[0]   <= i_tag;
                for (int k = 1; k < DELAY; k++) begin
                    r_valid[k] <= r_valid[k-1];
                    r_tag[k]   <= r_tag[k-1];
                end
            end
        end

        always_comb begin
            w_busy = 1'b0;
            for (int k = 0; k < DELAY; k++) begin
                w_busy = w_busy | (|r_valid[k]);
            end
        end

        assign busy    = w_busy;
        assign o_valid = r_valid[DELAY-1];
        assign o_tag   = r_tag[DELAY-1];

`ifdef MATCH_PIPE_INFLIGHT_EN
        // The counter tracks exactly the bits held in the stages, so it is
        // bounded by CHANNELS*DELAY and CNT_WIDTH is sized to hold that.
        logic [CNT_WIDTH-1:0] r_cnt;
        logic [CNT_WIDTH-1:0] w_cnt_next;

        always_comb begin
            w_cnt_next = CNT_WIDTH'(int'(r_cnt) + popcnt(i_valid)
                                    - popcnt(r_valid[DELAY-1]));
        end

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                r_cnt <= '0;
            end else if (en) begin
                r_cnt <= w_cnt_next;
            end
        end

        assign inflight = r_cnt;
`else
        assign inflight = '0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_match_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_match_pipe
//  Purpose  : Directed self-checking bench for match_pipe. Four instances
//             share clock and control: u_d4 (1 ch, DELAY 4), u_c2 (2 ch),
//             u_c3 (3 ch) and u_d0 (DELAY 0 pass-through).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_match_pipe;

`ifdef MATCH_PIPE_INFLIGHT_EN
    localparam bit INF_EN = 1'b1;
`else
    localparam bit INF_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       en;
    logic       flush;
    logic [2:0] vin;
    logic [7:0] tag;

    logic       ov4;  logic [7:0] ot4;  logic busy4;  logic [2:0] inf4;
    logic [1:0] ov2;  logic [7:0] ot2;  logic busy2;  logic [3:0] inf2;
    logic [2:0] ov3;  logic [7:0] ot3;  logic busy3;  logic [3:0] inf3;
    logic [1:0] ov0;  logic [7:0] ot0;  logic busy0;  logic       inf0;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    match_pipe #(.CHANNELS(1), .TAG_WIDTH(8), .DELAY(4)) u_d4 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .i_valid(vin[0:0]), .i_tag(tag),
        .o_valid(ov4), .o_tag(ot4), .busy(busy4), .inflight(inf4));

    match_pipe #(.CHANNELS(2), .TAG_WIDTH(8), .DELAY(4)) u_c2 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .i_valid(vin[1:0]), .i_tag(tag),
        .o_valid(ov2), .o_tag(ot2), .busy(busy2), .inflight(inf2));

    match_pipe #(.CHANNELS(3), .TAG_WIDTH(8), .DELAY(4)) u_c3 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .i_valid(vin), .i_tag(tag),
        .o_valid(ov3), .o_tag(ot3), .busy(busy3), .inflight(inf3));

    match_pipe #(.CHANNELS(2), .TAG_WIDTH(8), .DELAY(0)) u_d0 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .i_valid(vin[1:0]), .i_tag(tag),
        .o_valid(ov0), .o_tag(ot0), .busy(busy0), .inflight(inf0));

    task automatic check_eq(input string name, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int exp_inf(input int n);
        return INF_EN ? n : 0;
    endfunction

    // Advance past one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; flush = 1'b0; vin = '0; tag = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0; vin = '0; tag = '0;
        tick();
        tick();
        reset = 1'b0;

        // ---- reset state
        check_eq("rst_ov",   32'(ov4),   0);
        check_eq("rst_ot",   32'(ot4),   0);
        check_eq("rst_busy", 32'(busy4), 0);
        check_eq("rst_inf",  32'(inf4),  0);

        // ---- latency: accept in cycle 0, appear in cycle 4 only
        en = 1'b1; vin = 3'b001; tag = 8'hA5;
        tick();
        vin = '0; tag = 8'h00;
        check_eq("lat_ov_c1",   32'(ov4),   0);
        check_eq("lat_busy_c1", 32'(busy4), 1);
        check_eq("lat_inf_c1",  32'(inf4),  32'(exp_inf(1)));
        for (int c = 2; c <= 5; c++) begin
            tick();
            check_eq("lat_ov", 32'(ov4), (c == 4) ? 1 : 0);
            if (c == 4) begin
                check_eq("lat_ot",     32'(ot4),  32'h0000_00A5);
                check_eq("lat_inf_c4", 32'(inf4), 32'(exp_inf(1)));
            end
        end
        check_eq("lat_busy_end", 32'(busy4), 0);
        check_eq("lat_inf_end",  32'(inf4),  0);

        // ---- stall: en low in cycles 2..4 pushes output to cycle 7
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            en  = !(c >= 2 && c <= 4);
            vin = (c == 0) ? 3'b001 : 3'b000;
            tag = (c == 0) ? 8'h3C : 8'hFF;
            tick();
            check_eq("stall_ov", 32'(ov4), (c + 1 == 7) ? 1 : 0);
            if (c + 1 == 7) check_eq("stall_ot", 32'(ot4), 32'h0000_003C);
            if (c + 1 == 5) check_eq("stall_inf", 32'(inf4), 32'(exp_inf(1)));
        end

        // ---- flush with en=0 on a full 2-channel pipe
        do_reset();
        en = 1'b1; vin = 3'b011; tag = 8'h11;
        for (int c = 0; c < 4; c++) tick();
        check_eq("fl_full_ov",   32'(ov2),   32'h3);
        check_eq("fl_full_busy", 32'(busy2), 1);
        check_eq("fl_full_inf",  32'(inf2),  32'(exp_inf(8)));
        flush = 1'b1; en = 1'b0; vin = 3'b011; tag = 8'h77;
        tick();
        flush = 1'b0;
        check_eq("fl_ov",   32'(ov2),   0);
        check_eq("fl_busy", 32'(busy2), 0);
        check_eq("fl_inf",  32'(inf2),  0);
        en = 1'b1; vin = '0; tag = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("fl_drain_ov", 32'(ov2), 0);
        end

        // ---- inflight counter, 3 channels held high
        do_reset();
        en = 1'b1; vin = 3'b111; tag = 8'h42;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_eq("cnt_inf", 32'(inf3), 32'(exp_inf((3*i > 12) ? 12 : 3*i)));
        end
        check_eq("cnt_ov", 32'(ov3), 32'h7);

        // ---- reset mid-stream with a full pipe
        do_reset();
        en = 1'b1; vin = 3'b001;
        for (int c = 0; c < 4; c++) begin
            tag = 8'(c + 1);
            tick();
        end
        check_eq("mid_full_ov", 32'(ov4), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_ov",   32'(ov4),   0);
        check_eq("mid_ot",   32'(ot4),   0);
        check_eq("mid_busy", 32'(busy4), 0);
        check_eq("mid_inf",  32'(inf4),  0);
        vin = 3'b001; tag = 8'h5A;
        tick();
        vin = '0; tag = '0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            check_eq("mid_lat_ov", 32'(ov4), (c == 4) ? 1 : 0);
            if (c == 4) check_eq("mid_lat_ot", 32'(ot4), 32'h0000_005A);
        end

        // ---- DELAY=0 pass-through, en/flush toggling
        for (int i = 0; i < 8; i++) begin
            vin   = 3'(i);
            tag   = 8'(8'h81 ^ (i * 37));
            en    = i[0];
            flush = i[1];
            #1;
            check_eq("d0_ov",   32'(ov0),   32'(i & 3));
            check_eq("d0_ot",   32'(ot0),   32'(8'(8'h81 ^ (i * 37))));
            check_eq("d0_busy", 32'(busy0), 0);
            check_eq("d0_inf",  32'(inf0),  0);
            tick();
        end
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
